// File: rtl/gait_pkg.sv
// gait_pkg: shared constants, state encoding and the leg-gait table for the
// crabdle gait sequencer.
//   frame_len/base_len/scale_len : PWM timing derived from a clock frequency
//   FRAME/BASE/SCALE             : timing at the 12 MHz system clock
//   NEUTRAL                      : centre position code for every servo
//   state_t                      : sequencer states IDLE, RUN, PARK
//   GAIT                         : 8 rows x 4 legs of position codes
package gait_pkg;

    localparam int DEF_CLK_HZ = 12000000;

    // 50 Hz PWM frame
    function automatic int frame_len(input int clk_hz);
        return clk_hz / 50;
    endfunction

    // 1 ms minimum pulse
    function automatic int base_len(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // cycles per position code so that code 255 lands just under 2 ms
    function automatic int scale_len(input int clk_hz);
        return clk_hz / 256000;
    endfunction

    localparam int FRAME   = frame_len(DEF_CLK_HZ);
    localparam int BASE    = base_len(DEF_CLK_HZ);
    localparam int SCALE   = scale_len(DEF_CLK_HZ);
    localparam int NEUTRAL = 128;

    typedef enum logic [1:0] {IDLE, RUN, PARK} state_t;

    localparam int GAIT_ROWS = 8;
    localparam int GAIT_COLS = 4;

    typedef logic [7:0] gait_pos_t;

    localparam gait_pos_t GAIT [GAIT_ROWS][GAIT_COLS] = '{
        '{8'd64,  8'd192, 8'd64,  8'd192},
        '{8'd96,  8'd160, 8'd96,  8'd160},
        '{8'd128, 8'd128, 8'd128, 8'd128},
        '{8'd160, 8'd96,  8'd160, 8'd96 },
        '{8'd192, 8'd64,  8'd192, 8'd64 },
        '{8'd160, 8'd96,  8'd160, 8'd96 },
        '{8'd128, 8'd128, 8'd128, 8'd128},
        '{8'd96,  8'd160, 8'd96,  8'd160}
    };

endpackage

// File: rtl/gait_sequencer_pwm_channel.sv
// servo_pwm_channel: one hobby-servo PWM output.
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : frame-boundary strobe; copies i_target into the shadow
//   i_frame_cnt : shared position within the current PWM frame
//   i_target    : requested position code
//   o_pwm       : registered PWM line
// The shadow register keeps the pulse width constant for a whole frame so a
// target change can never produce a runt or stretched pulse.
module servo_pwm_channel
    import gait_pkg::*;
#(
    parameter int FCW       = 18,
    parameter int POS_W     = 8,
    parameter int BASE_CYC  = BASE,
    parameter int SCALE_CYC = SCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [FCW-1:0]   i_frame_cnt,
    input  logic [POS_W-1:0] i_target,
    output logic             o_pwm
);

    logic [POS_W-1:0] r_shadow;
    logic [FCW-1:0]   w_width;
    logic             r_pwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= POS_W'(NEUTRAL);
        end else if (i_load) begin
            r_shadow <= i_target;
        end
    end

    // Largest width (BASE + 255*SCALE) is below one frame, so FCW bits suffice.
    assign w_width = FCW'(BASE_CYC) + FCW'(r_shadow) * FCW'(SCALE_CYC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (i_frame_cnt < w_width);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/gait_sequencer.sv
// gait_sequencer: steps through the leg-gait table on each heartrate tick and
// drives NUM_SERVOS servo PWM lines.
//   clk, reset : clock, synchronous active-high reset
//   tick       : 1-cycle step strobe
//   enable     : 1 = walk, 0 = park then stop
//   dir        : 0 = forward, 1 = reverse (sampled on tick only)
//   step_idx   : current gait row
//   step_done  : 1-cycle pulse accompanying each step_idx change
//   busy       : sequencer is not IDLE
//   servo_pwm  : registered PWM lines, bit i = servo i
module gait_sequencer
    import gait_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int NUM_SERVOS = 4,
    parameter int STEPS      = 8,
    parameter int POS_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     enable,
    input  logic                     dir,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_done,
    output logic                     busy,
    output logic [NUM_SERVOS-1:0]    servo_pwm
);

    localparam int FRAME_CYC = frame_len(CLK_HZ);
    localparam int FCW       = $clog2(FRAME_CYC);
    localparam int SW        = $clog2(STEPS);

    logic [FCW-1:0] r_frame_cnt;
    logic           w_frame_last;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [SW-1:0]  r_step_idx;
    logic           r_step_done;
    logic           r_park_seen;
    logic           w_advance;
    logic [2:0]     w_row;

    assign w_frame_last = (r_frame_cnt == FCW'(FRAME_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable takes priority over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                if (!enable)   w_state_nxt = PARK;
                else if (tick) w_advance   = 1'b1;
            end
            PARK: begin
                if (enable)                           w_state_nxt = RUN;
                else if (w_frame_last && r_park_seen) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_step_idx  <= '0;
            r_step_done <= 1'b0;
            r_park_seen <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + FCW'(1);
            r_step_done <= w_advance;
            // STEPS is a power of two, so natural wrap gives mod-STEPS stepping.
            if (w_advance) begin
                r_step_idx <= dir ? r_step_idx - SW'(1) : r_step_idx + SW'(1);
            end
            // First frame boundary in PARK loads neutral; the next one ends PARK.
            r_park_seen <= (r_state == PARK) && (r_park_seen || w_frame_last);
        end
    end

    assign w_row = 3'(r_step_idx);

    for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_ch
        localparam logic [1:0] COL = 2'(g % GAIT_COLS);
        logic [POS_W-1:0] w_target;

        assign w_target = (r_state == RUN) ? POS_W'(GAIT[w_row][COL])
                                           : POS_W'(NEUTRAL);

        servo_pwm_channel #(
            .FCW       (FCW),
            .POS_W     (POS_W),
            .BASE_CYC  (base_len(CLK_HZ)),
            .SCALE_CYC (scale_len(CLK_HZ))
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_load      (w_frame_last),
            .i_frame_cnt (r_frame_cnt),
            .i_target    (w_target),
            .o_pwm       (servo_pwm[g])
        );
    end

    assign step_idx  = r_step_idx;
    assign step_done = r_step_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gait_sequencer.sv
// Directed bench for gait_sequencer. A 256 kHz clock setting keeps frames
// short: FRAME = 5120, BASE = 256, SCALE = 1, so width = 256 + position.
module tb_gait_sequencer;

    localparam int CLK_HZ = 256000;
    localparam int NS     = 4;
    localparam int STEPS  = 8;
    localparam int POS_W  = 8;
    localparam int FRAME  = 5120;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            tick   = 1'b0;
    logic            enable = 1'b0;
    logic            dir    = 1'b0;
    logic [2:0]      step_idx;
    logic            step_done;
    logic            busy;
    logic [NS-1:0]   servo_pwm;

    int n_vec  = 0;
    int n_miss = 0;
    int fc     = 0;
    int sd_cnt = 0;
    int acc   [NS];
    int wlast [NS];
    int fwd_seq [9];
    int sd0;

    always #5 clk = ~clk;

    gait_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .NUM_SERVOS (NS),
        .STEPS      (STEPS),
        .POS_W      (POS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .dir       (dir),
        .step_idx  (step_idx),
        .step_done (step_done),
        .busy      (busy),
        .servo_pwm (servo_pwm)
    );

    // Bench copy of the frame position, restarted by reset.
    always @(posedge clk) begin
        fc <= (reset || fc == FRAME - 1) ? 0 : fc + 1;
    end

    // Per-frame high-cycle count of each servo line, plus step_done pulse count.
    always @(negedge clk) begin
        if (step_done) sd_cnt <= sd_cnt + 1;
        for (int i = 0; i < NS; i++) begin
            if (fc == 0) begin
                wlast[i] <= acc[i];
                acc[i]   <= int'(servo_pwm[i]);
            end else begin
                acc[i] <= acc[i] + int'(servo_pwm[i]);
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_fc(input int target);
        int k;
        k = 0;
        while (fc != target && k < FRAME + 2) begin
            cyc(1);
            k++;
        end
        if (fc != target) chk("sync_timeout", fc, target);
    endtask

    // Returns one cycle into a new frame, with wlast holding the finished frame.
    task automatic end_frame();
        to_fc(0);
        cyc(1);
    endtask

    task automatic chk_w(input string tag, input int a, input int b,
                         input int c, input int d);
        int e [NS];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("%s_w%0d", tag, i), wlast[i], e[i]);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    initial begin
        fwd_seq[0] = 1; fwd_seq[1] = 2; fwd_seq[2] = 3; fwd_seq[3] = 4;
        fwd_seq[4] = 5; fwd_seq[5] = 6; fwd_seq[6] = 7; fwd_seq[7] = 0;
        fwd_seq[8] = 1;

        // Reset values
        reset = 1'b1;
        cyc(3);
        chk("rst_pwm",  int'(servo_pwm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx",  int'(step_idx), 0);
        chk("rst_done", int'(step_done), 0);
        reset = 1'b0;

        // Idle: ticks ignored, neutral pulses for two frames
        cyc(2);
        pulse_tick();
        chk("idle_tick_idx", int'(step_idx), 0);
        chk("idle_busy", int'(busy), 0);
        end_frame();
        end_frame();
        chk_w("idle", 384, 384, 384, 384);
        chk("idle_busy2", int'(busy), 0);
        chk("idle_idx2", int'(step_idx), 0);

        // Enable: busy next cycle, row 0 only from the next frame
        enable = 1'b1;
        cyc(1);
        chk("en_busy", int'(busy), 1);
        end_frame();
        chk_w("en_cur", 384, 384, 384, 384);
        end_frame();
        chk_w("row0", 320, 448, 320, 448);

        // Forward run through the wrap
        sd0 = sd_cnt;
        for (int k = 0; k < 9; k++) begin
            pulse_tick();
            chk($sformatf("fwd_idx%0d", k), int'(step_idx), fwd_seq[k]);
            chk($sformatf("fwd_done%0d", k), int'(step_done), 1);
            cyc(1);
            chk($sformatf("fwd_nodone%0d", k), int'(step_done), 0);
        end
        chk("fwd_done_count", sd_cnt - sd0, 9);
        end_frame();
        chk_w("fwd_hold", 320, 448, 320, 448);
        end_frame();
        chk_w("row1", 352, 416, 352, 416);

        // Reverse wrap 1 -> 0 -> 7; dir alone does nothing
        dir = 1'b1;
        pulse_tick();
        chk("rev_idx0", int'(step_idx), 0);
        cyc(1);
        pulse_tick();
        chk("rev_idx7", int'(step_idx), 7);
        cyc(1);
        dir = 1'b0;
        cyc(3);
        chk("dir_only_idx", int'(step_idx), 7);
        chk("dir_only_done", int'(step_done), 0);
        end_frame();
        end_frame();
        chk_w("row7", 352, 416, 352, 416);

        // Mid-frame step (during the pulse) does not disturb the current frame
        to_fc(100);
        pulse_tick();
        chk("mid_idx", int'(step_idx), 0);
        end_frame();
        chk_w("mid_cur", 352, 416, 352, 416);
        end_frame();
        chk_w("mid_next", 320, 448, 320, 448);

        // enable falls with a tick: no step, park, then idle
        enable = 1'b0;
        tick   = 1'b1;
        cyc(1);
        tick   = 1'b0;
        chk("park_idx", int'(step_idx), 0);
        chk("park_busy", int'(busy), 1);
        chk("park_done", int'(step_done), 0);
        end_frame();
        chk_w("park_cur", 320, 448, 320, 448);
        chk("park_busy2", int'(busy), 1);
        end_frame();
        chk_w("park_neu", 384, 384, 384, 384);
        chk("park_idle_busy", int'(busy), 0);
        chk("park_idle_idx", int'(step_idx), 0);

        // Reset in the middle of a pulse
        enable = 1'b1;
        cyc(2);
        pulse_tick();
        to_fc(200);
        chk("pre_rst_pwm", int'(servo_pwm), 15);
        chk("pre_rst_idx", int'(step_idx), 1);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_pwm",  int'(servo_pwm), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_idx",  int'(step_idx), 0);
        chk("mid_rst_done", int'(step_done), 0);
        reset  = 1'b0;
        enable = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
